// File: rtl/twiddle64_pkg.sv
// twiddle64_pkg: shared constants, twiddle exponent decode and DW saturation helpers
package twiddle64_pkg;
    localparam int N = 64;
    localparam int IDX_W = 6;
    localparam int NCONST = 9;

    typedef struct packed {
        logic [1:0] q;
        logic       swap;
        logic [3:0] idx;
    } decode_t;

    function automatic decode_t decode(input logic [IDX_W-1:0] e);
        decode_t d;
        d.q = e[5:4];
        d.swap = e[3:0] > 4'd8;
        // 16-f folded into 4 bits is exact for f in 9..15
        d.idx = d.swap ? 4'd0 - e[3:0] : e[3:0];
        return d;
    endfunction

    function automatic logic signed [31:0] sat_dw(input logic signed [31:0] v, input int dw);
        logic signed [31:0] mx;
        mx = (32'sd1 <<< (dw - 1)) - 32'sd1;
        return (v > mx) ? mx : (v < -mx - 32'sd1) ? -mx - 32'sd1 : v;
    endfunction
endpackage

// File: rtl/twiddle64_combine_if.sv
// twiddle64_combine_if: product-set input bus and complex result output of the combine stage
interface twiddle64_combine_if import twiddle64_pkg::*; #(parameter int DW = 14);
    logic                 din_valid;
    logic                 din_sof;
    logic [NCONST*DW-1:0] rere_bus;
    logic [NCONST*DW-1:0] imim_bus;
    logic [NCONST*DW-1:0] reim_bus;
    logic [NCONST*DW-1:0] imre_bus;
    logic                 dout_valid;
    logic                 dout_sof;
    logic [DW-1:0]        dout_real;
    logic [DW-1:0]        dout_imag;
    logic                 frame_err;

    modport master (output din_valid, din_sof, rere_bus, imim_bus, reim_bus, imre_bus,
                    input dout_valid, dout_sof, dout_real, dout_imag, frame_err);
    modport slave (input din_valid, din_sof, rere_bus, imim_bus, reim_bus, imre_bus,
                   output dout_valid, dout_sof, dout_real, dout_imag, frame_err);
endinterface

// File: rtl/twiddle64_idx_gen.sv
// twiddle64_idx_gen: frame sample counter, sof resync/error flag and twiddle exponent decode
module twiddle64_idx_gen import twiddle64_pkg::*; #(
    parameter int STAGE = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din_valid,
    input  logic       din_sof,
    output logic [3:0] idx,
    output logic [1:0] q,
    output logic       swap,
    output logic       frame_err
);
    localparam int L = N >> STAGE;
    localparam logic [IDX_W-1:0] MASK = IDX_W'(L - 1);
    localparam logic [IDX_W-1:0] HALF = IDX_W'(L / 2);

    logic [IDX_W-1:0] n_q, n_d, index, m, e;
    logic             frame_err_q, frame_err_d;
    decode_t          dec;

    always_comb begin
        index = (din_valid && din_sof) ? '0 : n_q;
        n_d = din_valid ? index + 6'd1 : n_q;
        frame_err_d = din_valid && din_sof && (n_q != '0);
        m = index & MASK;
        e = (m < HALF) ? '0 : (m - HALF) << STAGE;
        dec = decode(e);
        idx = dec.idx;
        q = dec.q;
        swap = dec.swap;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            n_q <= '0;
            frame_err_q <= 1'b0;
        end else begin
            n_q <= n_d;
            frame_err_q <= frame_err_d;
        end

    assign frame_err = frame_err_q;
endmodule

// File: rtl/twiddle64_combine.sv
// twiddle64_combine: selects one twiddle product set per sample, applies symmetry and
// saturates the complex product; two register stages from din_valid to dout_valid.
module twiddle64_combine import twiddle64_pkg::*; #(
    parameter int DATA_WIDTH = 14,
    parameter int STAGE = 0
) (
    input logic clk,
    input logic rst,
    twiddle64_combine_if.slave io
);
    localparam int DW = DATA_WIDTH;

    logic [3:0] idx;
    logic [1:0] q;
    logic       swap;

    twiddle64_idx_gen #(.STAGE(STAGE)) u_idx_gen (
        .clk(clk), .rst(rst), .din_valid(io.din_valid), .din_sof(io.din_sof),
        .idx(idx), .q(q), .swap(swap), .frame_err(io.frame_err)
    );

    logic signed [DW-1:0] s1_rere_q, s1_rere_d, s1_imim_q, s1_imim_d;
    logic signed [DW-1:0] s1_reim_q, s1_reim_d, s1_imre_q, s1_imre_d;
    logic [1:0]           s1_q_q, s1_q_d;
    logic                 s1_swap_q, s1_swap_d, s1_valid_q, s1_valid_d, s1_sof_q, s1_sof_d;
    logic                 dout_valid_q, dout_valid_d, dout_sof_q, dout_sof_d;
    logic [DW-1:0]        dout_real_q, dout_real_d, dout_imag_q, dout_imag_d;
    logic signed [31:0]   pr, pi, re, im, re_s, im_s;

    always_comb begin
        s1_rere_d = io.rere_bus[idx*DW +: DW];
        s1_imim_d = io.imim_bus[idx*DW +: DW];
        s1_reim_d = io.reim_bus[idx*DW +: DW];
        s1_imre_d = io.imre_bus[idx*DW +: DW];
        s1_q_d = q;
        s1_swap_d = swap;
        s1_valid_d = io.din_valid;
        s1_sof_d = io.din_valid && io.din_sof;
    end

    // Wide intermediates keep -(-2^DW) exact before saturation
    always_comb begin
        pr = s1_swap_q ? 32'(s1_reim_q) + 32'(s1_imre_q) : 32'(s1_rere_q) + 32'(s1_imim_q);
        pi = s1_swap_q ? 32'(s1_imim_q) - 32'(s1_rere_q) : 32'(s1_imre_q) - 32'(s1_reim_q);
        re = (s1_q_q == 2'd0) ? pr : (s1_q_q == 2'd1) ? pi : (s1_q_q == 2'd2) ? -pr : -pi;
        im = (s1_q_q == 2'd0) ? pi : (s1_q_q == 2'd1) ? -pr : (s1_q_q == 2'd2) ? -pi : pr;
        re_s = sat_dw(re, DW);
        im_s = sat_dw(im, DW);
        dout_valid_d = s1_valid_q;
        dout_sof_d = s1_valid_q && s1_sof_q;
        dout_real_d = s1_valid_q ? re_s[DW-1:0] : dout_real_q;
        dout_imag_d = s1_valid_q ? im_s[DW-1:0] : dout_imag_q;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            s1_rere_q <= '0;
            s1_imim_q <= '0;
            s1_reim_q <= '0;
            s1_imre_q <= '0;
            s1_q_q <= '0;
            s1_swap_q <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_sof_q <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_sof_q <= 1'b0;
            dout_real_q <= '0;
            dout_imag_q <= '0;
        end else begin
            s1_rere_q <= s1_rere_d;
            s1_imim_q <= s1_imim_d;
            s1_reim_q <= s1_reim_d;
            s1_imre_q <= s1_imre_d;
            s1_q_q <= s1_q_d;
            s1_swap_q <= s1_swap_d;
            s1_valid_q <= s1_valid_d;
            s1_sof_q <= s1_sof_d;
            dout_valid_q <= dout_valid_d;
            dout_sof_q <= dout_sof_d;
            dout_real_q <= dout_real_d;
            dout_imag_q <= dout_imag_d;
        end

    assign io.dout_valid = dout_valid_q;
    assign io.dout_sof = dout_sof_q;
    assign io.dout_real = dout_real_q;
    assign io.dout_imag = dout_imag_q;
endmodule

// File: tb/tb_twiddle64_combine.sv
// tb_twiddle64_combine: directed vectors on STAGE=0 and STAGE=1 instances fed identical input
module tb_twiddle64_combine;
    localparam int DW = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int tb_n = 0;
    int rr[9], ii[9], ri[9], ir[9];

    twiddle64_combine_if #(.DW(DW)) io ();
    twiddle64_combine_if #(.DW(DW)) io1 ();

    assign io1.din_valid = io.din_valid;
    assign io1.din_sof = io.din_sof;
    assign io1.rere_bus = io.rere_bus;
    assign io1.imim_bus = io.imim_bus;
    assign io1.reim_bus = io.reim_bus;
    assign io1.imre_bus = io.imre_bus;

    twiddle64_combine #(.DATA_WIDTH(DW), .STAGE(0)) dut (.clk(clk), .rst(rst), .io(io));
    twiddle64_combine #(.DATA_WIDTH(DW), .STAGE(1)) dut1 (.clk(clk), .rst(rst), .io(io1));

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_prod();
        for (int k = 0; k < 9; k++) begin
            rr[k] = 0; ii[k] = 0; ri[k] = 0; ir[k] = 0;
        end
    endtask

    task automatic send(input logic v, input logic s);
        io.din_valid = v;
        io.din_sof = s;
        for (int k = 0; k < 9; k++) begin
            io.rere_bus[k*DW +: DW] = DW'(rr[k]);
            io.imim_bus[k*DW +: DW] = DW'(ii[k]);
            io.reim_bus[k*DW +: DW] = DW'(ri[k]);
            io.imre_bus[k*DW +: DW] = DW'(ir[k]);
        end
        step();
        if (v) tb_n = ((s ? 0 : tb_n) + 1) % 64;
    endtask

    task automatic goto_n(input int t);
        clear_prod();
        send(1'b1, 1'b1);
        repeat (t - 1) send(1'b1, 1'b0);
    endtask

    function automatic void model(input int index, input int stage, output int re, output int im);
        int l, m, e, f, k, pr, pi, r, i;
        l = 64 >> stage;
        m = index % l;
        e = (m < l / 2) ? 0 : (m - l / 2) << stage;
        f = e % 16;
        k = (f <= 8) ? f : 16 - f;
        if (f <= 8) begin
            pr = rr[k] + ii[k]; pi = ir[k] - ri[k];
        end else begin
            pr = ri[k] + ir[k]; pi = ii[k] - rr[k];
        end
        case (e / 16)
            0: begin r = pr; i = pi; end
            1: begin r = pi; i = -pr; end
            2: begin r = -pr; i = -pi; end
            default: begin r = -pi; i = pr; end
        endcase
        re = (r > 8191) ? 8191 : (r < -8192) ? -8192 : r;
        im = (i > 8191) ? 8191 : (i < -8192) ? -8192 : i;
    endfunction

    task automatic test_reset();
        io.din_valid = 1'b0;
        io.din_sof = 1'b0;
        clear_prod();
        step();
        checks++;
        if (io.dout_valid !== 1'b0 || io.dout_real !== '0 || io.frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_init: valid=%b real=%0d ferr=%b, want 0/0/0", io.dout_valid, io.dout_real, io.frame_err);
        end
        rst = 1'b0;
        rr[0] = 5; ii[0] = 6; ir[0] = 9; ri[0] = 2;
        send(1'b1, 1'b1);
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if (io.dout_valid !== 1'b0 || io.dout_real !== '0 || io.dout_imag !== '0) begin
            errors++;
            $display("FAIL reset_midframe: valid=%b real=%0d imag=%0d, want 0/0/0", io.dout_valid, io.dout_real, io.dout_imag);
        end
        io.din_valid = 1'b0;
        step();
        rst = 1'b0;
        tb_n = 0;
        step();
        checks++;
        if (io.dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_output: valid=%b want 0", io.dout_valid);
        end
        send(1'b1, 1'b1);
        checks++;
        if (io.frame_err !== 1'b0 || io.dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_sof: ferr=%b valid=%b, want 0/0", io.frame_err, io.dout_valid);
        end
        send(1'b0, 1'b0);
        checks++;
        if (io.dout_valid !== 1'b1 || io.dout_sof !== 1'b1 || $signed(io.dout_real) !== 14'sd11 || $signed(io.dout_imag) !== 14'sd7) begin
            errors++;
            $display("FAIL reset_sof_out: valid=%b sof=%b real=%0d imag=%0d, want 1/1/11/7",
                     io.dout_valid, io.dout_sof, $signed(io.dout_real), $signed(io.dout_imag));
        end
    endtask

    task automatic test_direct();
        goto_n(40);
        rr[8] = 100; ii[8] = 50; ir[8] = 70; ri[8] = 20;
        send(1'b1, 1'b0);
        clear_prod();
        send(1'b0, 1'b0);
        checks++;
        if (io.dout_valid !== 1'b1 || $signed(io.dout_real) !== 14'sd150 || $signed(io.dout_imag) !== 14'sd50) begin
            errors++;
            $display("FAIL n40_idx8: valid=%b real=%0d imag=%0d, want 1/150/50", io.dout_valid, $signed(io.dout_real), $signed(io.dout_imag));
        end
        goto_n(44);
        ri[4] = 30; ir[4] = 40; ii[4] = 90; rr[4] = 10;
        send(1'b1, 1'b0);
        clear_prod();
        send(1'b0, 1'b0);
        checks++;
        if ($signed(io.dout_real) !== 14'sd70 || $signed(io.dout_imag) !== 14'sd80) begin
            errors++;
            $display("FAIL n44_swap: real=%0d imag=%0d, want 70/80", $signed(io.dout_real), $signed(io.dout_imag));
        end
        goto_n(52);
        rr[4] = 100; ii[4] = 0; ir[4] = 60; ri[4] = 10;
        send(1'b1, 1'b0);
        clear_prod();
        send(1'b0, 1'b0);
        checks++;
        if ($signed(io.dout_real) !== 14'sd50 || $signed(io.dout_imag) !== -14'sd100) begin
            errors++;
            $display("FAIL n52_q1: real=%0d imag=%0d, want 50/-100", $signed(io.dout_real), $signed(io.dout_imag));
        end
    endtask

    task automatic test_saturation();
        clear_prod();
        rr[0] = 8000; ii[0] = 8000;
        send(1'b1, 1'b1);
        clear_prod();
        send(1'b0, 1'b0);
        checks++;
        if ($signed(io.dout_real) !== 14'sd8191 || $signed(io.dout_imag) !== 14'sd0) begin
            errors++;
            $display("FAIL sat_pos: real=%0d imag=%0d, want 8191/0", $signed(io.dout_real), $signed(io.dout_imag));
        end
        goto_n(48);
        rr[0] = -8192;
        send(1'b1, 1'b0);
        clear_prod();
        send(1'b0, 1'b0);
        checks++;
        if ($signed(io.dout_imag) !== 14'sd8191 || $signed(io.dout_real) !== 14'sd0) begin
            errors++;
            $display("FAIL sat_negmin: real=%0d imag=%0d, want 0/8191", $signed(io.dout_real), $signed(io.dout_imag));
        end
    endtask

    task automatic test_frame_err();
        goto_n(10);
        rr[0] = 7; ii[0] = 8;
        send(1'b1, 1'b1);
        checks++;
        if (io.frame_err !== 1'b1) begin
            errors++;
            $display("FAIL ferr_pulse: frame_err=%b want 1", io.frame_err);
        end
        clear_prod();
        send(1'b0, 1'b0);
        checks++;
        if (io.frame_err !== 1'b0 || io.dout_sof !== 1'b1 || $signed(io.dout_real) !== 14'sd15) begin
            errors++;
            $display("FAIL ferr_end: frame_err=%b sof=%b real=%0d, want 0/1/15", io.frame_err, io.dout_sof, $signed(io.dout_real));
        end
        goto_n(40);
        rr[0] = 7; ii[0] = 8; rr[8] = 1000;
        send(1'b1, 1'b1);
        clear_prod();
        send(1'b0, 1'b0);
        checks++;
        if ($signed(io.dout_real) !== 14'sd15 || io.dout_sof !== 1'b1) begin
            errors++;
            $display("FAIL resync_index0: real=%0d sof=%b, want 15/1", $signed(io.dout_real), io.dout_sof);
        end
    endtask

    task automatic test_stage1();
        goto_n(17);
        rr[2] = 33; ii[2] = 44; rr[0] = 1;
        send(1'b1, 1'b0);
        clear_prod();
        send(1'b0, 1'b0);
        checks++;
        if ($signed(io1.dout_real) !== 14'sd77 || $signed(io.dout_real) !== 14'sd1) begin
            errors++;
            $display("FAIL stage1_n17: s1_real=%0d s0_real=%0d, want 77/1", $signed(io1.dout_real), $signed(io.dout_real));
        end
    endtask

    task automatic test_back_to_back();
        logic v, pv, psof, have;
        int cr0, ci0, cr1, ci1, pr0, pi0, pr1, pi1, lr0, li0, lr1, li1;
        for (int k = 0; k < 9; k++) begin
            rr[k] = 100 * k + 3; ii[k] = 50 * k - 7; ri[k] = -30 * k + 11; ir[k] = 70 * k + 5;
        end
        rr[8] = 8000; ii[8] = 7000; ir[8] = -8000; ri[8] = 3000;
        pv = 1'b0; psof = 1'b0; have = 1'b0;
        pr0 = 0; pi0 = 0; pr1 = 0; pi1 = 0; lr0 = 0; li0 = 0; lr1 = 0; li1 = 0;
        for (int t = 0; t < 240; t++) begin
            v = (t == 0) || ($urandom_range(0, 9) < 7);
            if (v) begin
                model((t == 0) ? 0 : tb_n, 0, cr0, ci0);
                model((t == 0) ? 0 : tb_n, 1, cr1, ci1);
            end
            send(v, t == 0);
            checks++;
            if (io.dout_valid !== pv || io1.dout_valid !== pv || io.dout_sof !== psof) begin
                errors++;
                $display("FAIL b2b_valid t=%0d: valid=%b/%b sof=%b, want %b/%b", t, io.dout_valid, io1.dout_valid, io.dout_sof, pv, psof);
            end
            if (pv) begin
                checks++;
                if (io.dout_real !== DW'(pr0) || io.dout_imag !== DW'(pi0) || io1.dout_real !== DW'(pr1) || io1.dout_imag !== DW'(pi1)) begin
                    errors++;
                    $display("FAIL b2b_data t=%0d: got %0d,%0d/%0d,%0d want %0d,%0d/%0d,%0d", t,
                             $signed(io.dout_real), $signed(io.dout_imag), $signed(io1.dout_real), $signed(io1.dout_imag), pr0, pi0, pr1, pi1);
                end
                lr0 = pr0; li0 = pi0; lr1 = pr1; li1 = pi1; have = 1'b1;
            end else if (have) begin
                checks++;
                if (io.dout_real !== DW'(lr0) || io.dout_imag !== DW'(li0) || io1.dout_real !== DW'(lr1) || io1.dout_imag !== DW'(li1)) begin
                    errors++;
                    $display("FAIL b2b_hold t=%0d: got %0d,%0d/%0d,%0d want %0d,%0d/%0d,%0d", t,
                             $signed(io.dout_real), $signed(io.dout_imag), $signed(io1.dout_real), $signed(io1.dout_imag), lr0, li0, lr1, li1);
                end
            end
            pv = v; psof = (t == 0);
            pr0 = cr0; pi0 = ci0; pr1 = cr1; pi1 = ci1;
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_saturation();
        test_frame_err();
        test_stage1();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
